// File: rtl/colour_pkg.sv
// Shared types and defaults for the colour write controller: FSM encoding,
// frame constants, channel byte and packed pixel-pair payload.
package colour_pkg;

    localparam int unsigned RGB_BASE_DEF  = 146944;
    localparam int unsigned NUM_PAIRS_DEF = 19200;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned WORD_W        = 16;

    typedef logic [BYTE_W-1:0] chan_byte_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WR0,
        S_WR1,
        S_WR2,
        S_FIN
    } state_t;

    typedef struct packed {
        chan_byte_t r_e;
        chan_byte_t g_e;
        chan_byte_t b_e;
        chan_byte_t r_o;
        chan_byte_t g_o;
        chan_byte_t b_o;
    } pair_t;

endpackage

// File: rtl/colour_clip8.sv
// Signed IN_W channel to 8-bit byte. With COLOUR_WR_CLIP_EN defined the value
// saturates to [0,255]; otherwise the low byte passes through and wraps.
module colour_clip8
    import colour_pkg::*;
#(
    parameter int unsigned IN_W = 16
) (
    input  logic [IN_W-1:0]   value,
    output logic [BYTE_W-1:0] clipped_c
);

`ifdef COLOUR_WR_CLIP_EN
    localparam logic [IN_W-1:0] MAX_BYTE = IN_W'(255);

    // Sign bit set means negative; otherwise an unsigned compare suffices.
    always_comb begin
        clipped_c = value[BYTE_W-1:0];
        if (value[IN_W-1]) begin
            clipped_c = '0;
        end else if (value > MAX_BYTE) begin
            clipped_c = '1;
        end
    end
`else
    logic unused_high;

    assign unused_high = ^value[IN_W-1:BYTE_W];
    assign clipped_c   = value[BYTE_W-1:0];
`endif

endmodule

// File: rtl/colour_write_controller.sv
// Packs converted RGB pixel pairs into three 16-bit SRAM words at sequential
// addresses from RGB_BASE; COLOUR_WR_CLIP_EN selects saturating channel bytes.
module colour_write_controller
    import colour_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 18,
    parameter logic [ADDR_W-1:0] RGB_BASE  = ADDR_W'(RGB_BASE_DEF),
    parameter int unsigned       NUM_PAIRS = NUM_PAIRS_DEF,
    parameter int unsigned       IN_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [IN_W-1:0]   r_e,
    input  logic [IN_W-1:0]   g_e,
    input  logic [IN_W-1:0]   b_e,
    input  logic [IN_W-1:0]   r_o,
    input  logic [IN_W-1:0]   g_o,
    input  logic [IN_W-1:0]   b_o,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [WORD_W-1:0] sram_wdata,
    output logic              sram_wen,
    output logic              done,
    output logic              busy
);

    localparam int unsigned      CNT_W     = $clog2(NUM_PAIRS + 1);
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(NUM_PAIRS - 1);

    state_t              state_q, state_d;
    pair_t               hold_q, hold_d, in_pair;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   offset_q, offset_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [WORD_W-1:0]   wdata_d;
    logic                ready_d, wen_d, done_d, busy_d;
    logic                accept;
    logic                last_pair;
    logic [IN_W-1:0]     chan_in [6];
    chan_byte_t          chan_byte [6];

    // Six channel saturators, even pixel first, in SRAM packing order.
    assign chan_in = '{r_e, g_e, b_e, r_o, g_o, b_o};

    for (genvar i = 0; i < 6; i++) begin : g_clip
        colour_clip8 #(.IN_W(IN_W)) u_clip (
            .value     (chan_in[i]),
            .clipped_c (chan_byte[i])
        );
    end

    assign in_pair   = {chan_byte[0], chan_byte[1], chan_byte[2],
                        chan_byte[3], chan_byte[4], chan_byte[5]};
    assign last_pair = (cnt_q == LAST_PAIR);

    // Next state, datapath updates, and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        accept   = 1'b0;
        ready_d  = 1'b0;
        wen_d    = 1'b0;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        wdata_d  = '0;
        addr_d   = '0;

        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                offset_d = '0;
                if (start) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (pix_valid) begin
                    accept  = 1'b1;
                    state_d = S_WR0;
                end
            end
            S_WR0: begin
                offset_d = offset_q + ADDR_W'(1);
                state_d  = S_WR1;
            end
            S_WR1: begin
                offset_d = offset_q + ADDR_W'(1);
                state_d  = S_WR2;
            end
            S_WR2: begin
                offset_d = offset_q + ADDR_W'(1);
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_pair) begin
                    state_d = S_FIN;
                end else if (pix_valid) begin
                    accept  = 1'b1;
                    state_d = S_WR0;
                end else begin
                    state_d = S_ARMED;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            hold_d = in_pair;
        end

        // Outputs are decoded from the state being entered so they register in step with it.
        case (state_d)
            S_ARMED: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_WR0: begin
                wen_d   = 1'b1;
                busy_d  = 1'b1;
                wdata_d = {hold_d.r_e, hold_d.g_e};
            end
            S_WR1: begin
                wen_d   = 1'b1;
                busy_d  = 1'b1;
                wdata_d = {hold_d.b_e, hold_d.r_o};
            end
            S_WR2: begin
                wen_d   = 1'b1;
                busy_d  = 1'b1;
                ready_d = (cnt_d != LAST_PAIR);
                wdata_d = {hold_d.g_o, hold_d.b_o};
            end
            S_FIN: begin
                done_d = 1'b1;
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase

        addr_d = RGB_BASE + offset_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            cnt_q      <= '0;
            offset_q   <= '0;
            pix_ready  <= 1'b0;
            sram_addr  <= RGB_BASE;
            sram_wdata <= '0;
            sram_wen   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            offset_q   <= offset_d;
            pix_ready  <= ready_d;
            sram_addr  <= addr_d;
            sram_wdata <= wdata_d;
            sram_wen   <= wen_d;
            done       <= done_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_colour_write_controller.sv
// Bench for colour_write_controller: single-pair vector table on a one-pair
// frame instance, and random frames on a four-pair instance against a reference model.
module tb_colour_write_controller;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned IN_W   = 16;
    localparam int unsigned BASE   = 146944;
    localparam int unsigned NP     = 4;
    localparam int unsigned NVEC   = 6;

    typedef struct { int r_e; int g_e; int b_e; int r_o; int g_o; int b_o; } ref_pair_t;
    typedef struct { ref_pair_t px; logic [15:0] w0; logic [15:0] w1; logic [15:0] w2; } vec_t;
    typedef struct { int addr; int data; int cyc; } wr_t;

    logic              clk, rst, start, pix_valid;
    logic [IN_W-1:0]   r_e, g_e, b_e, r_o, g_o, b_o;
    logic              ready4, wen4, done4, busy4;
    logic [ADDR_W-1:0] addr4;
    logic [15:0]       wdata4;
    logic              ready1, wen1, done1, busy1;
    logic [ADDR_W-1:0] addr1;
    logic [15:0]       wdata1;

    int        total;
    int        bad;
    int        cyc;
    wr_t       wr_q[$];
    int        done_q[$];
    int        done_busy_q[$];
    ref_pair_t exp_q[$];
    int        acc_q[$];
    int        gap_tab[NP];
    vec_t      vt[NVEC];

    colour_write_controller #(.NUM_PAIRS(NP)) dut (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_ready(ready4),
        .r_e(r_e), .g_e(g_e), .b_e(b_e), .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .sram_addr(addr4), .sram_wdata(wdata4), .sram_wen(wen4), .done(done4), .busy(busy4)
    );

    colour_write_controller #(.NUM_PAIRS(1)) dut_one (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_ready(ready1),
        .r_e(r_e), .g_e(g_e), .b_e(b_e), .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .sram_addr(addr1), .sram_wdata(wdata1), .sram_wen(wen1), .done(done1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor for the four-pair instance.
    always @(negedge clk) begin
        if (wen4) wr_q.push_back('{int'(addr4), int'(wdata4), cyc});
        if (done4) begin
            done_q.push_back(cyc);
            done_busy_q.push_back(int'(busy4));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ch_byte(input int v);
        logic [31:0] u;
        u = v;
`ifdef COLOUR_WR_CLIP_EN
        if (v < 0) return 8'h00;
        if (v > 255) return 8'hFF;
`endif
        return u[7:0];
    endfunction

    function automatic logic [15:0] word_of(input ref_pair_t p, input int k);
        if (k == 0) return {ch_byte(p.r_e), ch_byte(p.g_e)};
        if (k == 1) return {ch_byte(p.b_e), ch_byte(p.r_o)};
        return {ch_byte(p.g_o), ch_byte(p.b_o)};
    endfunction

    function automatic ref_pair_t mk(input int a, input int b, input int c,
                                     input int d, input int e, input int f);
        ref_pair_t p;
        p.r_e = a; p.g_e = b; p.b_e = c; p.r_o = d; p.g_o = e; p.b_o = f;
        return p;
    endfunction

    function automatic int rch();
        return int'($urandom_range(0, 1100)) - 400;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input ref_pair_t p);
        r_e = 16'(p.r_e); g_e = 16'(p.g_e); b_e = 16'(p.b_e);
        r_o = 16'(p.r_o); g_o = 16'(p.g_o); b_o = 16'(p.b_o);
    endtask

    task automatic clear_log();
        wr_q.delete(); done_q.delete(); done_busy_q.delete();
        exp_q.delete(); acc_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; pix_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offers NP pairs to the four-pair instance, honouring gap_tab idle cycles before each.
    task automatic send_frame();
        ref_pair_t p;
        bit hs;
        int guard;
        for (int i = 0; i < int'(NP); i++) begin
            if (gap_tab[i] > 0) begin
                pix_valid = 1'b0;
                repeat (gap_tab[i]) tick();
                if (gap_tab[i] >= 4) begin
                    check("stall_wen", 32'(wen4), 32'd0);
                    check("stall_ready", 32'(ready4), 32'd1);
                    check("stall_addr", 32'(addr4), 32'(BASE + 3 * i));
                end
            end
            p = mk(rch(), rch(), rch(), rch(), rch(), rch());
            drive(p);
            pix_valid = 1'b1;
            guard = 0;
            hs = 1'b0;
            do begin
                hs = ready4;
                if (hs) acc_q.push_back(cyc);
                tick();
                guard++;
            end while (!hs && guard < 50);
            check("handshake", 32'(hs), 32'd1);
            exp_q.push_back(p);
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done_q.size() == 0 && guard < 40) begin
            tick();
            guard++;
        end
        tick();
    endtask

    // Every write must land at BASE+3p+k with the model's word, three cycles after acceptance.
    task automatic check_frame(input string tag);
        int p, k, acc;
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(3 * NP));
        check({tag, "_ndone"}, 32'(done_q.size()), 32'd1);
        for (int i = 0; i < wr_q.size() && i < int'(3 * NP); i++) begin
            p = i / 3;
            k = i % 3;
            acc = (p < acc_q.size()) ? acc_q[p] : -100;
            check({tag, "_addr"}, 32'(wr_q[i].addr), 32'((BASE + i) % (1 << ADDR_W)));
            check({tag, "_data"}, 32'(wr_q[i].data), 32'(word_of(exp_q[p], k)));
            check({tag, "_wcyc"}, 32'(wr_q[i].cyc), 32'(acc + 1 + k));
        end
        if (done_q.size() > 0 && wr_q.size() > 0) begin
            check({tag, "_done_cyc"}, 32'(done_q[0]), 32'(wr_q[wr_q.size() - 1].cyc + 1));
            check({tag, "_busy_at_done"}, 32'(done_busy_q[0]), 32'd0);
        end
    endtask

    initial begin
        int viol;
        total = 0; bad = 0;
        rst = 1'b0; start = 1'b0; pix_valid = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0));

        vt[0].px = mk('h12, 'h34, 'h56, 'h78, 'h9A, 'hBC);
        vt[0].w0 = 16'h1234; vt[0].w1 = 16'h5678; vt[0].w2 = 16'h9ABC;
        vt[1].px = mk(-5, 300, 255, 0, 128, 1000);
        vt[2].px = mk(0, 0, 0, 0, 0, 0);
        vt[2].w0 = 16'h0000; vt[2].w1 = 16'h0000; vt[2].w2 = 16'h0000;
        vt[3].px = mk(255, 255, 255, 255, 255, 255);
        vt[3].w0 = 16'hFFFF; vt[3].w1 = 16'hFFFF; vt[3].w2 = 16'hFFFF;
        vt[4].px = mk(-1, 256, -32768, 32767, 7, 200);
        vt[5].px = mk(1, 2, 3, 4, 5, 6);
        vt[5].w0 = 16'h0102; vt[5].w1 = 16'h0304; vt[5].w2 = 16'h0506;
`ifdef COLOUR_WR_CLIP_EN
        vt[1].w0 = 16'h00FF; vt[1].w1 = 16'hFF00; vt[1].w2 = 16'h80FF;
        vt[4].w0 = 16'h00FF; vt[4].w1 = 16'h00FF; vt[4].w2 = 16'h07C8;
`else
        vt[1].w0 = 16'hFB2C; vt[1].w1 = 16'hFF00; vt[1].w2 = 16'h80E8;
        vt[4].w0 = 16'hFF00; vt[4].w1 = 16'h00FF; vt[4].w2 = 16'h07C8;
`endif

        // Reset values while held in reset.
        tick(); tick();
        check("rst_ready", 32'(ready4), 32'd0);
        check("rst_wen", 32'(wen4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_addr", 32'(addr4), 32'(BASE));
        check("rst_wdata", 32'(wdata4), 32'd0);

        // pix_valid without start must be ignored.
        rst = 1'b1;
        tick();
        pix_valid = 1'b1;
        viol = 0;
        repeat (6) begin
            tick();
            if (ready4 || wen4 || ready1 || wen1) viol++;
        end
        check("idle_quiet", 32'(viol), 32'd0);
        check("idle_addr", 32'(addr4), 32'(BASE));
        pix_valid = 1'b0;

        // start and pix_valid together: pair accepted only in the following cycle.
        do_reset();
        drive(vt[0].px);
        start = 1'b1;
        pix_valid = 1'b1;
        tick();
        start = 1'b0;
        check("same_cyc_wen", 32'(wen1), 32'd0);
        check("same_cyc_ready", 32'(ready1), 32'd1);
        tick();
        pix_valid = 1'b0;
        check("same_cyc_w0", 32'(wdata1), 32'h1234);
        check("same_cyc_a0", 32'(addr1), 32'(BASE));
        tick(); tick(); tick(); tick();

        // Single-pair frames from the vector table.
        do_reset();
        for (int v = 0; v < int'(NVEC); v++) begin
            pulse_start();
            check("vec_armed_ready", 32'(ready1), 32'd1);
            check("vec_armed_busy", 32'(busy1), 32'd1);
            drive(vt[v].px);
            pix_valid = 1'b1;
            tick();
            pix_valid = 1'b0;
            check("vec_wen0", 32'(wen1), 32'd1);
            check("vec_addr0", 32'(addr1), 32'(BASE));
            check("vec_word0", 32'(wdata1), 32'(vt[v].w0));
            tick();
            check("vec_addr1", 32'(addr1), 32'(BASE + 1));
            check("vec_word1", 32'(wdata1), 32'(vt[v].w1));
            tick();
            check("vec_addr2", 32'(addr1), 32'(BASE + 2));
            check("vec_word2", 32'(wdata1), 32'(vt[v].w2));
            check("vec_last_ready", 32'(ready1), 32'd0);
            tick();
            check("vec_done", 32'(done1), 32'd1);
            check("vec_done_busy", 32'(busy1), 32'd0);
            check("vec_done_wen", 32'(wen1), 32'd0);
            tick();
            check("vec_done_pulse", 32'(done1), 32'd0);
        end

        // Back-to-back frame with pix_valid held high.
        do_reset();
        clear_log();
        for (int i = 0; i < int'(NP); i++) gap_tab[i] = 0;
        pulse_start();
        send_frame();
        wait_done();
        check_frame("b2b");
        if (done_q.size() > 0 && acc_q.size() > 0)
            check("b2b_done_at_13", 32'(done_q[0]), 32'(acc_q[0] + 13));

        // Stalls between pairs.
        clear_log();
        gap_tab[0] = 0; gap_tab[1] = 8; gap_tab[2] = 0; gap_tab[3] = 5;
        pulse_start();
        send_frame();
        wait_done();
        check_frame("stall");

        // Random frames.
        for (int f = 0; f < 5; f++) begin
            clear_log();
            for (int i = 0; i < int'(NP); i++) gap_tab[i] = int'($urandom_range(0, 6));
            pulse_start();
            send_frame();
            wait_done();
            check_frame("rand");
        end

        // Reset during WR1 aborts at once; the next frame restarts at the base address.
        clear_log();
        pulse_start();
        drive(vt[0].px);
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        tick();
        check("pre_rst_wen", 32'(wen4), 32'd1);
        check("pre_rst_addr", 32'(addr4), 32'(BASE + 1));
        #2 rst = 1'b0;
        #1;
        check("mid_rst_wen", 32'(wen4), 32'd0);
        check("mid_rst_addr", 32'(addr4), 32'(BASE));
        check("mid_rst_busy", 32'(busy4), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        clear_log();
        for (int i = 0; i < int'(NP); i++) gap_tab[i] = int'($urandom_range(0, 2));
        pulse_start();
        send_frame();
        wait_done();
        check_frame("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
